williams_bus_arbiter: RTL and testbench

- Owns the shared 16-bit video/program RAM bus and splits it between the 6809 CPU and the SC1/SC2 blitter.
- On a blitter halt request it halts the CPU, waits for bus grant (BA/BS), and then sequences each blitter read and write as a mem_req/mem_ack transaction.
- It returns blt_ack and read data to the blitter, and hands the bus back to the CPU when the blitter drops halt.
- Sits between the CPU core, the blitter and the memory/nibble-write decoder.

---
 rtl/williams_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_williams_bus_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/williams_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : williams_bus_arbiter
// Purpose  : Shares the video/program RAM bus between the 6809 CPU and the
//            SC1/SC2 blitter using a HALT / BA-BS handshake.
// Revision : 1.0 - initial release
// ============================================================================
module williams_bus_arbiter #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_e_n,
  output logic        cpu_halt_n,
  input  logic        cpu_ba,
  input  logic        cpu_bs,
  input  logic        cpu_vma,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        blt_halt,
  output logic        blt_halt_ack,
  input  logic        blt_rd,
  input  logic        blt_wr,
  input  logic [15:0] blt_addr,
  input  logic [7:0]  blt_wdata,
  input  logic [1:0]  blt_nibble_en,
  output logic        blt_ack,
  output logic [7:0]  blt_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_nibble_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  localparam logic [2:0] c_S_CPU        = 3'd0;
  localparam logic [2:0] c_S_HALT_REQ   = 3'd1;
  localparam logic [2:0] c_S_BLT_IDLE   = 3'd2;
  localparam logic [2:0] c_S_BLT_ACCESS = 3'd3;
  localparam logic [2:0] c_S_BLT_DONE   = 3'd4;
  localparam logic [2:0] c_S_RELEASE    = 3'd5;

  localparam logic [7:0] c_TO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [1:0]  r_nib;
  logic        r_dir;
  logic [7:0]  r_cnt;
  logic [7:0]  r_rdata;
  logic        r_terr;

  logic        w_cpu_owns;
  logic        w_blt_owns;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_S_CPU;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_nib   <= 2'b00;
      r_dir   <= 1'b0;
      r_cnt   <= 8'h00;
      r_rdata <= 8'h00;
      r_terr  <= 1'b0;
    end else begin
      case (r_state)
        c_S_CPU: begin
          if (blt_halt) r_state <= c_S_HALT_REQ;
        end
        c_S_HALT_REQ: begin
          if (cpu_ba && cpu_bs) r_state <= c_S_BLT_IDLE;
          else if (!blt_halt)   r_state <= c_S_RELEASE;
        end
        c_S_BLT_IDLE: begin
          // A pending access wins over a simultaneous halt drop.
          if (blt_rd || blt_wr) begin
            r_addr  <= blt_addr;
            r_wdata <= blt_wdata;
            r_nib   <= blt_nibble_en;
            r_dir   <= blt_wr;
            r_cnt   <= 8'h00;
            r_state <= c_S_BLT_ACCESS;
          end else if (!blt_halt) begin
            r_state <= c_S_RELEASE;
          end
        end
        c_S_BLT_ACCESS: begin
          if (mem_ack) begin
            if (!r_dir) r_rdata <= mem_rdata;
            r_state <= c_S_BLT_DONE;
          end else if (r_cnt == c_TO_LAST) begin
            r_terr <= 1'b1;
            if (!r_dir) r_rdata <= 8'hFF;
            r_state <= c_S_BLT_DONE;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        c_S_BLT_DONE: begin
          if (en_e_n) r_state <= c_S_BLT_IDLE;
        end
        c_S_RELEASE: begin
          if (!cpu_ba) r_state <= c_S_CPU;
        end
        default: r_state <= c_S_CPU;
      endcase
    end
  end

  assign w_cpu_owns = (r_state == c_S_CPU) || (r_state == c_S_HALT_REQ) ||
                      (r_state == c_S_RELEASE);
  assign w_blt_owns = (r_state == c_S_BLT_IDLE) || (r_state == c_S_BLT_ACCESS) ||
                      (r_state == c_S_BLT_DONE);

  assign cpu_halt_n   = !((r_state == c_S_HALT_REQ) || w_blt_owns);
  assign blt_halt_ack = w_blt_owns;
  assign blt_ack      = (r_state == c_S_BLT_DONE);
  assign blt_rdata    = r_rdata;
  assign timeout_err  = r_terr;

  // CPU path is purely combinational so the CPU sees no added latency.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_nibble_we = 2'b00;
    mem_addr      = r_addr;
    mem_wdata     = r_wdata;
    if (w_cpu_owns) begin
      mem_req       = cpu_vma;
      mem_we        = !cpu_rw;
      mem_nibble_we = cpu_rw ? 2'b00 : 2'b11;
      mem_addr      = cpu_addr;
      mem_wdata     = cpu_data;
    end else if (r_state == c_S_BLT_ACCESS) begin
      mem_req       = 1'b1;
      mem_we        = r_dir;
      mem_nibble_we = r_dir ? r_nib : 2'b00;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_williams_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_williams_bus_arbiter
// Purpose  : Directed vectors and hand-written sequences for the bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_williams_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, en_e_n, cpu_halt_n, cpu_ba, cpu_bs, cpu_vma, cpu_rw;
  logic [15:0] cpu_addr, blt_addr, mem_addr;
  logic [7:0]  cpu_data, blt_wdata, blt_rdata, mem_wdata, mem_rdata;
  logic        blt_halt, blt_halt_ack, blt_rd, blt_wr, blt_ack;
  logic [1:0]  blt_nibble_en, mem_nibble_we;
  logic        mem_req, mem_we, mem_ack, timeout_err;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  williams_bus_arbiter #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .en_e_n(en_e_n), .cpu_halt_n(cpu_halt_n),
    .cpu_ba(cpu_ba), .cpu_bs(cpu_bs), .cpu_vma(cpu_vma), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .blt_halt(blt_halt),
    .blt_halt_ack(blt_halt_ack), .blt_rd(blt_rd), .blt_wr(blt_wr),
    .blt_addr(blt_addr), .blt_wdata(blt_wdata), .blt_nibble_en(blt_nibble_en),
    .blt_ack(blt_ack), .blt_rdata(blt_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_nibble_we(mem_nibble_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic        vma;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        e_req;
    logic        e_we;
    logic [1:0]  e_nib;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'hC800, 8'h5A, 1'b1, 1'b1, 2'b11};
    vecs[1] = '{1'b1, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b0, 2'b00};
    vecs[2] = '{1'b0, 1'b0, 16'h8000, 8'hC3, 1'b0, 1'b1, 2'b11};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 8'h77, 1'b1, 1'b0, 2'b00};

    rst_n = 0; en_e_n = 0; cpu_ba = 0; cpu_bs = 0; cpu_vma = 0; cpu_rw = 1;
    cpu_addr = 0; cpu_data = 0; blt_halt = 0; blt_rd = 0; blt_wr = 0;
    blt_addr = 0; blt_wdata = 0; blt_nibble_en = 0; mem_rdata = 0; mem_ack = 0;
    tick(); tick();
    chk("rst_halt_n", cpu_halt_n, 1); chk("rst_halt_ack", blt_halt_ack, 0);
    chk("rst_blt_ack", blt_ack, 0);   chk("rst_rdata", blt_rdata, 8'h00);
    chk("rst_terr", timeout_err, 0);
    rst_n = 1;
    tick();

    // CPU path vectors (combinational, S_CPU)
    for (int i = 0; i < 4; i++) begin
      cpu_vma = vecs[i].vma; cpu_rw = vecs[i].rw;
      cpu_addr = vecs[i].addr; cpu_data = vecs[i].data;
      #1;
      chk("cpu_req", mem_req, vecs[i].e_req);
      chk("cpu_we", mem_we, vecs[i].e_we);
      chk("cpu_nib", mem_nibble_we, vecs[i].e_nib);
      chk("cpu_addr", mem_addr, vecs[i].addr);
      chk("cpu_wdata", mem_wdata, vecs[i].data);
      chk("cpu_halt_n", cpu_halt_n, 1);
    end
    cpu_vma = 0; cpu_rw = 1;

    // Grant sequence
    blt_halt = 1;
    tick();
    chk("hreq_halt_n", cpu_halt_n, 0);
    chk("hreq_ack", blt_halt_ack, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hreq_wait_ack", blt_halt_ack, 0);
      chk("hreq_wait_req", mem_req, 0);
    end
    cpu_ba = 1; cpu_bs = 1;
    tick();
    chk("grant_ack", blt_halt_ack, 1);
    chk("grant_req", mem_req, 0);

    // Blitter read with ack after 3 clk
    blt_rd = 1; blt_addr = 16'h1234;
    tick();
    blt_rd = 0;
    chk("rd_req", mem_req, 1); chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 16'h1234); chk("rd_nib", mem_nibble_we, 2'b00);
    tick(); chk("rd_wait_req", mem_req, 1); chk("rd_wait_nib", mem_nibble_we, 2'b00);
    tick(); chk("rd_wait_ack", blt_ack, 0);
    mem_ack = 1; mem_rdata = 8'hA7;
    tick();
    mem_ack = 0; mem_rdata = 8'h00;
    chk("rd_blt_ack", blt_ack, 1); chk("rd_rdata", blt_rdata, 8'hA7);
    chk("rd_done_req", mem_req, 0);
    tick(); chk("rd_ack_hold", blt_ack, 1);
    en_e_n = 1;
    tick(); chk("rd_ack_drop", blt_ack, 0); chk("rd_idle_hack", blt_halt_ack, 1);

    // Blitter write, immediate ack, strobe already high; wr wins over rd
    blt_wr = 1; blt_rd = 1; blt_nibble_en = 2'b10; blt_wdata = 8'h30;
    blt_addr = 16'hABCD; mem_ack = 1;
    tick();
    blt_wr = 0; blt_rd = 0;
    chk("wr_req", mem_req, 1); chk("wr_we", mem_we, 1);
    chk("wr_nib", mem_nibble_we, 2'b10); chk("wr_wdata", mem_wdata, 8'h30);
    chk("wr_addr", mem_addr, 16'hABCD);
    tick();
    mem_ack = 0;
    chk("wr_ack", blt_ack, 1); chk("wr_nib_off", mem_nibble_we, 2'b00);
    chk("wr_rdata_kept", blt_rdata, 8'hA7);
    tick(); chk("wr_ack_1clk", blt_ack, 0);

    // Timeout read
    en_e_n = 0; blt_rd = 1; blt_addr = 16'h0100;
    tick();
    blt_rd = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_ack", blt_ack, 0);
      chk("to_wait_req", mem_req, 1);
      chk("to_wait_err", timeout_err, 0);
    end
    tick();
    chk("to_ack", blt_ack, 1); chk("to_rdata", blt_rdata, 8'hFF);
    chk("to_err", timeout_err, 1);
    en_e_n = 1;
    tick();
    blt_rd = 1; mem_ack = 1; mem_rdata = 8'h3C;
    tick();
    blt_rd = 0;
    tick();
    mem_ack = 0;
    chk("good_rdata", blt_rdata, 8'h3C); chk("to_err_sticky", timeout_err, 1);
    tick();
    chk("good_idle", blt_ack, 0);

    // Release from S_BLT_IDLE; re-assert of halt in release is ignored
    blt_halt = 0;
    tick();
    chk("rel_halt_n", cpu_halt_n, 1); chk("rel_hack", blt_halt_ack, 0);
    blt_halt = 1; cpu_vma = 1; cpu_rw = 1; cpu_addr = 16'h5555;
    tick();
    chk("rel_hold_halt_n", cpu_halt_n, 1);
    chk("rel_cpu_req", mem_req, 1); chk("rel_cpu_addr", mem_addr, 16'h5555);
    blt_halt = 0; cpu_ba = 0; cpu_bs = 0; cpu_vma = 0;
    tick();
    chk("cpu_back_halt_n", cpu_halt_n, 1);
    blt_halt = 1;
    tick();
    chk("s_cpu_reached", cpu_halt_n, 0);

    // Abort before grant: no halt_ack pulse
    blt_halt = 0;
    tick();
    chk("abort_halt_n", cpu_halt_n, 1); chk("abort_hack", blt_halt_ack, 0);
    tick();
    chk("abort_cpu_hack", blt_halt_ack, 0); chk("abort_cpu_halt_n", cpu_halt_n, 1);

    // Reset during S_BLT_ACCESS
    blt_halt = 1;
    tick();
    cpu_ba = 1; cpu_bs = 1;
    tick();
    blt_rd = 1; mem_ack = 0;
    tick();
    chk("ra_access_req", mem_req, 1);
    rst_n = 0; blt_rd = 0; blt_halt = 0; cpu_ba = 0; cpu_bs = 0; cpu_vma = 0;
    tick();
    rst_n = 1;
    chk("ra_halt_n", cpu_halt_n, 1); chk("ra_hack", blt_halt_ack, 0);
    chk("ra_req_lo", mem_req, 0);
    cpu_vma = 1;
    #1;
    chk("ra_req_hi", mem_req, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
